// File: rtl/chip8_alu_exec.sv
// rtl/chip8_alu_exec.sv - CHIP-8 execute sequencer for 7XNN/8XYn; drives the ALU and writes Vx then VF.
// CHIP8_LOGIC_VF_RESET_EN: when defined, 8XY1/8XY2/8XY3 also clear VF.
module chip8_alu_exec #(
    parameter int SHIFT_USES_VY = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] opcode,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic [3:0]  reg_raddr_a,
    input  logic [7:0]  reg_rdata_a,
    output logic [3:0]  reg_raddr_b,
    input  logic [7:0]  reg_rdata_b,
    output logic        reg_we,
    output logic [3:0]  reg_waddr,
    output logic [7:0]  reg_wdata,
    output logic [15:0] alu_in1,
    output logic [15:0] alu_in2,
    output logic [3:0]  alu_sel,
    input  logic [15:0] alu_out,
    input  logic        alu_carry
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_EXEC, S_WB_X, S_WB_F, S_DONE
    } state_t;

`ifdef CHIP8_LOGIC_VF_RESET_EN
    localparam logic LOGIC_VF = 1'b1;
`else
    localparam logic LOGIC_VF = 1'b0;
`endif

    function automatic logic op_legal(input logic [15:0] op);
        logic ok;
        ok = 1'b0;
        if (op[15:12] == 4'h7)
            ok = 1'b1;
        else if (op[15:12] == 4'h8)
            ok = (op[3:0] <= 4'h7) || (op[3:0] == 4'hE);
        return ok;
    endfunction

    function automatic logic op_writes_vf(input logic [15:0] op);
        logic wf;
        wf = 1'b0;
        if (op[15:12] == 4'h8) begin
            case (op[3:0])
                4'h4, 4'h5, 4'h6, 4'h7, 4'hE: wf = 1'b1;
                4'h1, 4'h2, 4'h3:             wf = LOGIC_VF;
                default:                      wf = 1'b0;
            endcase
        end
        return wf;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] op_q, op_d;
    logic        flag_q, flag_d;
    logic        wf_q, wf_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        illegal_q, illegal_d;
    logic [3:0]  raddr_a_q, raddr_a_d;
    logic [3:0]  raddr_b_q, raddr_b_d;
    logic        we_q, we_d;
    logic [3:0]  waddr_q, waddr_d;
    logic [7:0]  wdata_q, wdata_d;

    logic [7:0]  src;
    logic        flag_c;
    logic        unused_alu_hi;

    assign unused_alu_hi = &{1'b0, alu_out[15:8]};
    assign src = (SHIFT_USES_VY != 0) ? reg_rdata_b : reg_rdata_a;

    // ALU drive is combinational from the read ports, live only in EXEC.
    always_comb begin
        alu_sel = 4'd0;
        alu_in1 = 16'd0;
        alu_in2 = 16'd0;
        flag_c  = 1'b0;
        if (state_q == S_EXEC) begin
            if (op_q[15:12] == 4'h7) begin
                alu_sel = 4'd4;
                alu_in1 = {8'h00, reg_rdata_a};
                alu_in2 = {8'h00, op_q[7:0]};
            end else begin
                case (op_q[3:0])
                    4'h0: begin
                        alu_sel = 4'd1;
                        alu_in2 = {8'h00, reg_rdata_b};
                    end
                    4'h1, 4'h2, 4'h3: begin
                        alu_sel = op_q[3:0];
                        alu_in1 = {8'h00, reg_rdata_a};
                        alu_in2 = {8'h00, reg_rdata_b};
                    end
                    4'h4: begin
                        alu_sel = 4'd4;
                        alu_in1 = {8'h00, reg_rdata_a};
                        alu_in2 = {8'h00, reg_rdata_b};
                        flag_c  = alu_carry;
                    end
                    4'h5: begin
                        alu_sel = 4'd5;
                        alu_in1 = {8'h00, reg_rdata_a};
                        alu_in2 = {8'h00, reg_rdata_b};
                        flag_c  = (reg_rdata_a >= reg_rdata_b);
                    end
                    4'h7: begin
                        alu_sel = 4'd5;
                        alu_in1 = {8'h00, reg_rdata_b};
                        alu_in2 = {8'h00, reg_rdata_a};
                        flag_c  = (reg_rdata_b >= reg_rdata_a);
                    end
                    4'h6: begin
                        alu_sel = 4'd7;
                        alu_in1 = {8'h00, src};
                        alu_in2 = 16'd1;
                        flag_c  = src[0];
                    end
                    4'hE: begin
                        alu_sel = 4'd6;
                        alu_in1 = {8'h00, src};
                        alu_in2 = 16'd1;
                        flag_c  = src[7];
                    end
                    default: begin
                        alu_sel = 4'd0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        flag_d    = flag_q;
        wf_d      = wf_q;
        raddr_a_d = raddr_a_q;
        raddr_b_d = raddr_b_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        we_d      = 1'b0;
        waddr_d   = 4'd0;
        wdata_d   = 8'd0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op_legal(opcode)) begin
                        op_d      = opcode;
                        wf_d      = op_writes_vf(opcode);
                        raddr_a_d = opcode[11:8];
                        raddr_b_d = opcode[7:4];
                        state_d   = S_READ;
                    end else begin
                        done_d    = 1'b1;
                        illegal_d = 1'b1;
                        state_d   = S_DONE;
                    end
                end
            end
            S_READ: state_d = S_EXEC;
            S_EXEC: begin
                // The write-data register doubles as the captured result for WB_X.
                flag_d  = flag_c;
                we_d    = 1'b1;
                waddr_d = op_q[11:8];
                wdata_d = alu_out[7:0];
                state_d = S_WB_X;
            end
            S_WB_X: begin
                if (wf_q) begin
                    we_d    = 1'b1;
                    waddr_d = 4'hF;
                    wdata_d = {7'b0, flag_q};
                    state_d = S_WB_F;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WB_F: begin
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= 16'd0;
            flag_q    <= 1'b0;
            wf_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            raddr_a_q <= 4'd0;
            raddr_b_q <= 4'd0;
            we_q      <= 1'b0;
            waddr_q   <= 4'd0;
            wdata_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            flag_q    <= flag_d;
            wf_q      <= wf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            raddr_a_q <= raddr_a_d;
            raddr_b_q <= raddr_b_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign illegal     = illegal_q;
    assign reg_raddr_a = raddr_a_q;
    assign reg_raddr_b = raddr_b_q;
    assign reg_we      = we_q;
    assign reg_waddr   = waddr_q;
    assign reg_wdata   = wdata_q;

endmodule

// File: tb/tb_chip8_alu_exec.sv
// tb/tb_chip8_alu_exec.sv - table-driven bench for chip8_alu_exec with a register-file and ALU model.
`timescale 1ns/1ps
module tb_chip8_alu_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] opcode;
    logic        busy, done, illegal;
    logic [3:0]  reg_raddr_a, reg_raddr_b;
    logic [7:0]  reg_rdata_a, reg_rdata_b;
    logic        reg_we;
    logic [3:0]  reg_waddr;
    logic [7:0]  reg_wdata;
    logic [15:0] alu_in1, alu_in2, alu_out;
    logic [3:0]  alu_sel;
    logic        alu_carry;

    chip8_alu_exec dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode),
        .busy(busy), .done(done), .illegal(illegal),
        .reg_raddr_a(reg_raddr_a), .reg_rdata_a(reg_rdata_a),
        .reg_raddr_b(reg_raddr_b), .reg_rdata_b(reg_rdata_b),
        .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_carry(alu_carry)
    );

    always #5 clk = ~clk;

`ifdef CHIP8_LOGIC_VF_RESET_EN
    localparam bit LOGIC_VF = 1'b1;
`else
    localparam bit LOGIC_VF = 1'b0;
`endif

    // Register file: synchronous read, DUT write port has priority over bench preload.
    logic [7:0] rf [16];
    logic       pre_we = 1'b0;
    logic [3:0] pre_addr = 4'd0;
    logic [7:0] pre_data = 8'd0;

    always @(posedge clk) begin
        reg_rdata_a <= rf[reg_raddr_a];
        reg_rdata_b <= rf[reg_raddr_b];
        if (reg_we)
            rf[reg_waddr] <= reg_wdata;
        else if (pre_we)
            rf[pre_addr] <= pre_data;
    end

    always_comb begin
        alu_out   = 16'd0;
        alu_carry = 1'b0;
        case (alu_sel)
            4'd1: alu_out = alu_in1 | alu_in2;
            4'd2: alu_out = alu_in1 & alu_in2;
            4'd3: alu_out = alu_in1 ^ alu_in2;
            4'd4: begin
                alu_out   = alu_in1 + alu_in2;
                alu_carry = alu_out[8];
            end
            4'd5: alu_out = alu_in1 - alu_in2;
            4'd6: alu_out = alu_in1 << alu_in2[3:0];
            4'd7: alu_out = alu_in1 >> alu_in2[3:0];
            default: alu_out = 16'd0;
        endcase
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    int         r_lat, r_ill, r_nw;
    int         r_wk [2];
    logic [3:0] r_wa [2];
    logic [7:0] r_wd [2];

    // Latency k means done was seen in the cycle ending at edge T+k.
    task automatic run_op(input string tag, input logic [15:0] op, input bit hold,
                          input logic [15:0] alt_op);
        @(negedge clk);
        start  = 1'b1;
        opcode = op;
        @(posedge clk);
        #1;
        if (hold) opcode = alt_op;
        else      start  = 1'b0;
        r_lat = 0; r_ill = 0; r_nw = 0;
        for (int k = 1; k <= 12 && r_lat == 0; k++) begin
            @(negedge clk);
            if (reg_we) begin
                if (r_nw < 2) begin
                    r_wa[r_nw] = reg_waddr;
                    r_wd[r_nw] = reg_wdata;
                    r_wk[r_nw] = k;
                end
                r_nw++;
            end
            if (done) begin
                r_lat = k;
                r_ill = int'(illegal);
            end
        end
        start = 1'b0;
        if (r_lat == 0) chk({tag, "_timeout"}, 0, 1);
        @(negedge clk);
        chk({tag, "_busy_after"}, int'(busy), 0);
        chk({tag, "_done_width"}, int'(done), 0);
    endtask

    typedef struct {
        logic [15:0] op;
        logic [7:0]  xv, yv, fv, res;
        bit          vf_wr;
        logic [7:0]  vf;
        int          lat;
        bit          ill;
    } vec_t;

    vec_t vecs [18];

    initial begin
        vecs[0]  = '{16'h8354, 8'hF0, 8'h20, 8'h00, 8'h10, 1'b1, 8'h01, 5, 1'b0};
        vecs[1]  = '{16'h8125, 8'h05, 8'h07, 8'h00, 8'hFE, 1'b1, 8'h00, 5, 1'b0};
        vecs[2]  = '{16'h8125, 8'h07, 8'h05, 8'h00, 8'h02, 1'b1, 8'h01, 5, 1'b0};
        vecs[3]  = '{16'h8FFE, 8'h81, 8'h81, 8'h81, 8'h02, 1'b1, 8'h01, 5, 1'b0};
        vecs[4]  = '{16'h7702, 8'hFF, 8'h00, 8'h55, 8'h01, 1'b0, 8'h00, 4, 1'b0};
        vecs[5]  = '{16'h8AB9, 8'h12, 8'h34, 8'h66, 8'h00, 1'b0, 8'h00, 1, 1'b1};
        vecs[6]  = '{16'h8011, 8'h0F, 8'hF0, 8'h33, 8'hFF, LOGIC_VF, 8'h00, LOGIC_VF ? 5 : 4, 1'b0};
        vecs[7]  = '{16'h8230, 8'h11, 8'hAB, 8'h44, 8'hAB, 1'b0, 8'h00, 4, 1'b0};
        vecs[8]  = '{16'h8562, 8'h3C, 8'h0F, 8'h44, 8'h0C, LOGIC_VF, 8'h00, LOGIC_VF ? 5 : 4, 1'b0};
        vecs[9]  = '{16'h8563, 8'h3C, 8'h0F, 8'h44, 8'h33, LOGIC_VF, 8'h00, LOGIC_VF ? 5 : 4, 1'b0};
        vecs[10] = '{16'h8A47, 8'h10, 8'h30, 8'h00, 8'h20, 1'b1, 8'h01, 5, 1'b0};
        vecs[11] = '{16'h8A47, 8'h22, 8'h22, 8'h00, 8'h00, 1'b1, 8'h01, 5, 1'b0};
        vecs[12] = '{16'h8A45, 8'h22, 8'h22, 8'h00, 8'h00, 1'b1, 8'h01, 5, 1'b0};
        vecs[13] = '{16'h8B26, 8'h03, 8'h80, 8'h00, 8'h01, 1'b1, 8'h01, 5, 1'b0};
        vecs[14] = '{16'h8C5E, 8'h7F, 8'h01, 8'h00, 8'hFE, 1'b1, 8'h00, 5, 1'b0};
        vecs[15] = '{16'h8F14, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b1, 8'h01, 5, 1'b0};
        vecs[16] = '{16'hE09E, 8'h09, 8'h0A, 8'h77, 8'h00, 1'b0, 8'h00, 1, 1'b1};
        vecs[17] = '{16'h8008, 8'h5A, 8'h5A, 8'h77, 8'h00, 1'b0, 8'h00, 1, 1'b1};

        for (int i = 0; i < 16; i++) rf[i] = 8'h00;
        reset  = 1'b1;
        start  = 1'b0;
        opcode = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_illegal", int'(illegal), 0);
        chk("rst_we", int'(reg_we), 0);
        chk("rst_sel", int'(alu_sel), 0);
        chk("rst_wdata", int'(reg_wdata), 0);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            automatic logic [3:0] x = vecs[i].op[11:8];
            automatic logic [3:0] y = vecs[i].op[7:4];
            automatic int exp_nw = vecs[i].ill ? 0 : (vecs[i].vf_wr ? 2 : 1);
            automatic logic [7:0] exp_x, exp_f;
            automatic string t = $sformatf("v%0d", i);
            preload(4'hF, vecs[i].fv);
            preload(y, vecs[i].yv);
            preload(x, vecs[i].xv);
            run_op(t, vecs[i].op, 1'b0, 16'h0000);
            chk({t, "_lat"}, r_lat, vecs[i].lat);
            chk({t, "_illegal"}, r_ill, int'(vecs[i].ill));
            chk({t, "_nwrites"}, r_nw, exp_nw);
            if (exp_nw >= 1 && r_nw >= 1) begin
                chk({t, "_w0_addr"}, int'(r_wa[0]), int'(x));
                chk({t, "_w0_data"}, int'(r_wd[0]), int'(vecs[i].res));
                chk({t, "_w0_cycle"}, r_wk[0], 3);
            end
            if (exp_nw == 2 && r_nw >= 2) begin
                chk({t, "_w1_addr"}, int'(r_wa[1]), 15);
                chk({t, "_w1_data"}, int'(r_wd[1]), int'(vecs[i].vf));
                chk({t, "_w1_cycle"}, r_wk[1], 4);
            end
            exp_x = vecs[i].ill ? vecs[i].xv
                  : ((x == 4'hF && vecs[i].vf_wr) ? vecs[i].vf : vecs[i].res);
            exp_f = vecs[i].vf_wr ? vecs[i].vf
                  : ((x == 4'hF && !vecs[i].ill) ? vecs[i].res : vecs[i].fv);
            chk({t, "_final_x"}, int'(rf[x]), int'(exp_x));
            chk({t, "_final_f"}, int'(rf[15]), int'(exp_f));
        end

        // start held high through the whole instruction with a changing opcode
        preload(4'h1, 8'h05);
        preload(4'h2, 8'h03);
        preload(4'h0, 8'h99);
        run_op("hold", 16'h8124, 1'b1, 16'h8011);
        chk("hold_lat", r_lat, 5);
        chk("hold_nwrites", r_nw, 2);
        chk("hold_w0_data", int'(r_wd[0]), 8'h08);
        chk("hold_w1_data", int'(r_wd[1]), 8'h00);
        chk("hold_v0", int'(rf[0]), 8'h99);

        // reset asserted during WB_X aborts the instruction
        preload(4'hF, 8'h77);
        preload(4'h1, 8'h05);
        preload(4'h2, 8'h03);
        @(negedge clk);
        start  = 1'b1;
        opcode = 16'h8124;
        @(posedge clk);
        #1 start = 1'b0;
        begin
            automatic bit seen = 1'b0;
            for (int k = 0; k < 8 && !seen; k++) begin
                @(negedge clk);
                seen = reg_we;
            end
            chk("abort_reached_wbx", int'(seen), 1);
        end
        #1 reset = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_we", int'(reg_we), 0);
        chk("abort_waddr", int'(reg_waddr), 0);
        chk("abort_wdata", int'(reg_wdata), 0);
        chk("abort_raddr", int'(reg_raddr_a), 0);
        chk("abort_done", int'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        begin
            automatic int we_seen = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (reg_we) we_seen++;
            end
            chk("abort_no_we", we_seen, 0);
        end
        chk("abort_vf", int'(rf[15]), 8'h77);
        chk("abort_v1", int'(rf[1]), 8'h05);

        run_op("post", 16'h7101, 1'b0, 16'h0000);
        chk("post_lat", r_lat, 4);
        chk("post_v1", int'(rf[1]), 8'h06);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/chip8_alu_exec.md
Name: chip8_alu_exec

Overview:
- Execute-stage sequencer directly upstream of the CHIP-8 ALU; runs one register-arithmetic instruction (8XYn, 7XNN) per start request.
- Reads Vx/Vy from the V-register file (synchronous read, 1-cycle latency) and drives the ALU's operand and select inputs.
- Captures the ALU result, computes VF, and writes Vx and then VF back through the register-file write port.
- Sits between the instruction decoder (start/opcode/done handshake) and the register file.

Parameters:
- SHIFT_USES_VY, 0, 1: 8XY6/8XYE shift Vy into Vx (COSMAC); 0: shift Vx in place (CHIP-48).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- opcode  in  16  instruction; latched when start is accepted
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- illegal  out  1  valid with done; opcode not handled
- reg_raddr_a  out  4  read address, port A (Vx)
- reg_rdata_a  in  8  port A data, valid the cycle after the address
- reg_raddr_b  out  4  read address, port B (Vy)
- reg_rdata_b  in  8  port B data
- reg_we  out  1  write enable
- reg_waddr  out  4  write address
- reg_wdata  out  8  write data
- alu_in1  out  16  ALU operand 1, zero-extended
- alu_in2  out  16  ALU operand 2, zero-extended
- alu_sel  out  4  ALU function select
- alu_out  in  16  ALU result; bits [7:0] used
- alu_carry  in  1  ALU add carry

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-high (reset): state goes to IDLE; busy, done, illegal, reg_we, alu_sel, and all address/data outputs go to 0. An in-flight instruction is aborted with no further writes.
- States: IDLE, READ, EXEC, WB_X, WB_F, DONE.
- IDLE:
  - start=1 with a legal opcode: latch opcode, go to READ.
  - start=1 with an illegal opcode: go to DONE with illegal=1 and no register access.
  - Legal opcodes: 7XNN and 8XYn with n in {0,1,2,3,4,5,6,7,E}.
- READ: reg_raddr_a = x (op[11:8]), reg_raddr_b = y (op[7:4]). Go to EXEC.
- EXEC: alu_sel and operands are driven combinationally from the rdata ports. res_q <= alu_out[7:0] and flag_q are registered. Go to WB_X.
- Operation mapping (x=Vx, y=Vy):
  - 7XNN: sel 4, in1=x, in2=NN; VF not written.
  - 8XY0: sel 1, in1=0, in2=y; no VF.
  - 8XY1 / 8XY2 / 8XY3: sel 1 / 2 / 3 (x op y); no VF unless optional feature.
  - 8XY4: sel 4; flag = alu_carry.
  - 8XY5: sel 5, x-y; flag = (x >= y).
  - 8XY7: sel 5, in1=y, in2=x; flag = (y >= x).
  - 8XY6: sel 7, in2=1; src = SHIFT_USES_VY ? y : x; flag = src[0].
  - 8XYE: sel 6, in2=1; flag = src[7]; result truncated to 8 bits.
- WB_X: reg_we=1, reg_waddr=x, reg_wdata=res_q. Go to WB_F if the op writes VF, else DONE.
- WB_F: reg_we=1, reg_waddr=F, reg_wdata={7'b0,flag_q}. Go to DONE.
- VF is always written after Vx, so when x==F the flag value wins.
- DONE: done=1 for exactly one cycle; illegal holds its value for that cycle only. Go to IDLE. alu_sel=0 outside EXEC.
- Latency (start accepted at T): done at T+5 with VF write, T+4 without, T+1 when illegal. A new start is accepted at the earliest in the cycle after done.
- start while busy is ignored (not queued). Opcode changes after acceptance have no effect.
- reg_we is never high outside WB_X/WB_F, and at most 2 writes occur per instruction.

Optional Feature:
- CHIP8_LOGIC_VF_RESET_EN defined: 8XY1/2/3 also pass through WB_F writing VF=0; done at T+5.
- Not defined: logic ops never touch VF; done at T+4.

Test Plan:
- V3=0xF0, V5=0x20, opcode 0x8354 -> writes V3=0x10 at T+3, VF=0x01 at T+4, done at T+5, illegal=0.
- V1=0x05, V2=0x07, opcode 0x8125 -> V1=0xFE, VF=0x00. Then V1=0x07, V2=0x05, 0x8125 -> V1=0x02, VF=0x01.
- VF=0x81, opcode 0x8FFE (SHIFT_USES_VY=0) -> WB_X writes VF=0x02, then WB_F writes VF=0x01; final VF=0x01.
- V7=0xFF, opcode 0x7702 -> single write V7=0x01, no VF write, done at T+4. Opcode 0x8AB9 -> done at T+1 with illegal=1, reg_we never asserted.
- Second start held during busy on 0x8011 -> ignored. Reset asserted in WB_X of 0x8124 -> outputs 0 immediately, no VF write, busy=0.
- With CHIP8_LOGIC_VF_RESET_EN, V0=0x0F, V1=0xF0, opcode 0x8011 -> V0=0xFF, VF=0x00, done at T+5; without the macro, VF is unchanged and done is at T+4.
